bit_serializer: RTL and testbench

Parallel-to-serial front end for the bit-pattern detection path. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a single serial line. That line is the `in` input of the downstream sequence detector. A one-word holding register lets consecutive words stream with no idle bit between them.

---
 rtl/bit_serializer.sv | 103 ++++++++++
 tb/tb_bit_serializer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and
// shifts them out one bit per clock, with a one-word holding register for gapless streaming.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic             hold_vld, hold_vld_nxt;
  logic             accept;
  logic             last_bit;

  assign din_ready = rstn && !hold_vld;
  assign accept    = din_valid && din_ready;
  assign last_bit  = (cnt == CW'(WIDTH - 1));

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_nxt    = state;
    sreg_nxt     = sreg;
    cnt_nxt      = cnt;
    hold_nxt     = hold;
    hold_vld_nxt = hold_vld;

    unique case (state)
      IDLE: begin
        if (accept) begin
          sreg_nxt  = din;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          // Hold takes priority; an accept here is only possible when hold is empty.
          cnt_nxt = '0;
          if (hold_vld) begin
            sreg_nxt     = hold;
            hold_vld_nxt = 1'b0;
          end else if (accept) begin
            sreg_nxt = din;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          sreg_nxt = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
          cnt_nxt  = cnt + CW'(1);
          if (accept) begin
            hold_nxt     = din;
            hold_vld_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      hold_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hold_vld <= hold_vld_nxt;
    end
  end

  // NOTE: datapath registers are not reset; their contents only matter once a valid flag qualifies them.
  always_ff @(posedge clk) begin
    sreg <= sreg_nxt;
    hold <= hold_nxt;
  end

  assign out_valid   = (state == SHIFT);
  assign out         = out_valid ? (LSB_FIRST ? sreg[0] : sreg[WIDTH-1]) : IDLE_BIT;
  assign frame_start = out_valid && (cnt == '0);
  assign busy        = out_valid || hold_vld;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: an MSB-first and an LSB-first instance
// share stimulus and are compared each cycle against a word-queue reference model.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;

  logic m_ready, m_out, m_out_valid, m_frame_start, m_busy;
  logic l_ready, l_out, l_out_valid, l_frame_start, l_busy;

  bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .din_ready(m_ready),
    .out(m_out), .out_valid(m_out_valid), .frame_start(m_frame_start), .busy(m_busy)
  );

  bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_lsb (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .din_ready(l_ready),
    .out(l_out), .out_valid(l_out_valid), .frame_start(l_frame_start), .busy(l_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the word currently on the line (with bit position) plus at most one waiting word.
  bit         ref_active = 0;
  int         ref_pos = 0;
  logic [7:0] ref_word = '0;
  bit         ref_held = 0;
  logic [7:0] ref_hold = '0;
  bit         ref_acc = 0;

  // Captured output streams, oldest bit in the highest position.
  logic [63:0] cap_m, cap_l;
  int          n_bits, n_frames;

  task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
    ref_acc = r && v && !ref_held;
    if (!r) begin
      ref_active = 0;
      ref_held   = 0;
    end else begin
      if (ref_active) begin
        ref_pos++;
        if (ref_pos == 8) begin
          ref_active = 0;
          if (ref_held) begin
            ref_active = 1;
            ref_word   = ref_hold;
            ref_pos    = 0;
            ref_held   = 0;
          end
        end
      end
      if (ref_acc) begin
        if (!ref_active) begin
          ref_active = 1;
          ref_word   = d;
          ref_pos    = 0;
        end else begin
          ref_hold = d;
          ref_held = 1;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    logic exp_m, exp_l;
    rstn = r; din_valid = v; din = d;
    @(posedge clk);
    model_edge(r, v, d);
    #1;
    exp_m = ref_active ? ref_word[7 - ref_pos] : 1'b0;
    exp_l = ref_active ? ref_word[ref_pos]     : 1'b1;
    check("out_valid",   m_out_valid,   ref_active);
    check("out_msb",     m_out,         exp_m);
    check("frame_start", m_frame_start, ref_active && ref_pos == 0);
    check("busy",        m_busy,        ref_active || ref_held);
    check("din_ready",   m_ready,       r && !ref_held);
    check("lsb_out_valid", l_out_valid, ref_active);
    check("lsb_out",       l_out,       exp_l);
    check("lsb_busy",      l_busy,      ref_active || ref_held);
    if (m_out_valid) begin
      cap_m = {cap_m[62:0], m_out};
      n_bits++;
    end
    if (l_out_valid) cap_l = {cap_l[62:0], l_out};
    if (m_frame_start) n_frames++;
  endtask

  task automatic clear_capture();
    cap_m = '0; cap_l = '0; n_bits = 0; n_frames = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
  endtask

  // Hold a word valid until accepted, with a bounded wait.
  task automatic send(input logic [7:0] w);
    int tries;
    tries = 0;
    do begin
      step(1'b1, 1'b1, w);
      tries++;
    end while (!ref_acc && tries < 40);
    if (!ref_acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic       rv;
    logic [7:0] rd;
    bit         pending;

    // Reset state
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hAA);
    check("reset_ready", m_ready, 1'b0);
    idle(2);

    // Single MSB-first word
    clear_capture();
    send(8'hB0);
    idle(10);
    check("single_bits",   n_bits,      8);
    check("single_word",   cap_m[7:0],  8'hB0);
    check("single_frames", n_frames,    1);

    // Back-to-back stream, valid held high
    clear_capture();
    send(8'hA5);
    send(8'h3C);
    check("b2b_ready_low", m_ready, 1'b0);
    idle(20);
    check("b2b_bits",   n_bits,       16);
    check("b2b_stream", cap_m[15:0],  16'hA53C);
    check("b2b_frames", n_frames,     2);

    // Bypass on the last-bit edge with hold empty
    clear_capture();
    send(8'h0F);
    idle(7);
    check("bypass_ready", m_ready, 1'b1);
    step(1'b1, 1'b1, 8'hFF);
    check("bypass_accept", ref_acc, 1'b1);
    check("bypass_nogap_valid", m_out_valid, 1'b1);
    idle(10);
    check("bypass_stream", cap_m[15:0], 16'h0FFF);
    check("bypass_bits",   n_bits,      16);

    // LSB-first word
    clear_capture();
    send(8'h0D);
    idle(10);
    check("lsb_word", cap_l[7:0], 8'hB0);

    // Reset mid-word with a held word
    send(8'hB0);
    send(8'h55);
    idle(1);
    check("midreset_busy_before", m_busy, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    check("midreset_valid", m_out_valid, 1'b0);
    check("midreset_busy",  m_busy,      1'b0);
    check("midreset_out",   m_out,       1'b0);
    clear_capture();
    idle(20);
    check("midreset_no_bits", n_bits, 0);

    // Gap between words
    clear_capture();
    send(8'h80);
    idle(12);
    send(8'h01);
    idle(10);
    check("gap_frames", n_frames,    2);
    check("gap_stream", cap_m[15:0], 16'h8001);

    // Randomized traffic with occasional reset; din stays stable while pending
    pending = 0;
    rd = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pending) begin
        rv = ($urandom_range(0, 3) != 0);
        rd = 8'($urandom);
      end else begin
        rv = 1'b1;
      end
      if ($urandom_range(0, 59) == 0) begin
        step(1'b0, rv, rd);
        pending = 0;
      end else begin
        step(1'b1, rv, rd);
        pending = rv && !ref_acc;
      end
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
